// File: rtl/tls_pkg.sv
// rtl/tls_pkg.sv - shared phase encoding, lamp patterns and sizing helper for the intersection controller
package tls_pkg;

   typedef enum logic [1:0] {
      GREEN   = 2'd0,
      YELLOW  = 2'd1,
      ALL_RED = 2'd2,
      FLASH   = 2'd3
   } phase_t;

   // Lamp head ordering is {red, yellow, green}
   localparam logic [2:0] LAMP_RED = 3'b100;
   localparam logic [2:0] LAMP_YEL = 3'b010;
   localparam logic [2:0] LAMP_GRN = 3'b001;
   localparam logic [2:0] LAMP_OFF = 3'b000;

   function automatic int max_of4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/rr_next_sel.sv
// rtl/rr_next_sel.sv - round-robin next-requester search starting after the current owner
module rr_next_sel
   import tls_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] cur,
   output logic [$clog2(N)-1:0] next,
   output logic                 valid
);

   localparam int IW = $clog2(N);

   // Walk distances from farthest to nearest so the nearest requester wins; cur itself is distance N
   always_comb begin
      next  = cur;
      valid = 1'b0;
      for (int k = N; k >= 1; k--) begin
         if (req[(int'(cur) + k) % N]) begin
            next  = IW'((int'(cur) + k) % N);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/traffic_light_controller_n.sv
// rtl/traffic_light_controller_n.sv - N-approach round-robin signal controller with clearance and flashing mode
module traffic_light_controller_n
   import tls_pkg::*;
#(
   parameter int N_APPROACH = 4,
   parameter int MIN_GREEN  = 4,
   parameter int MAX_GREEN  = 8,
   parameter int YELLOW_T   = 2,
   parameter int ALLRED_T   = 1,
   parameter int FLASH_HALF = 2
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [N_APPROACH-1:0]             sensor,
   input  logic                              flash_en,
   output logic [N_APPROACH-1:0][2:0]        lights,
   output logic [$clog2(N_APPROACH)-1:0]     green_idx,
   output phase_t                            phase
);

   localparam int IW = $clog2(N_APPROACH);
   localparam int TW = $clog2(max_of4(MAX_GREEN, YELLOW_T, ALLRED_T, FLASH_HALF) + 1);

   localparam logic [TW-1:0] MIN_LAST = TW'(MIN_GREEN - 1);
   localparam logic [TW-1:0] MAX_LAST = TW'(MAX_GREEN - 1);
   localparam logic [TW-1:0] Y_LAST   = TW'(YELLOW_T - 1);
   localparam logic [TW-1:0] AR_LAST  = TW'(ALLRED_T - 1);
   localparam logic [TW-1:0] FH_LAST  = TW'(FLASH_HALF - 1);

   if (N_APPROACH < 2) begin : g_bad_n
      $error("N_APPROACH must be at least 2");
   end
   if (MIN_GREEN < 1) begin : g_bad_min
      $error("MIN_GREEN must be at least 1");
   end
   if (MAX_GREEN < MIN_GREEN) begin : g_bad_max
      $error("MAX_GREEN must be at least MIN_GREEN");
   end
   if (YELLOW_T < 1 || ALLRED_T < 1 || FLASH_HALF < 1) begin : g_bad_t
      $error("YELLOW_T, ALLRED_T and FLASH_HALF must be at least 1");
   end

   logic [TW-1:0]         timer;
   logic                  flash_phase;
   logic                  from_flash;
   logic [N_APPROACH-1:0] others;
   logic                  other_req;
   logic                  green_exit;
   logic [IW-1:0]         rr_next;
   logic                  rr_valid;

   assign others    = sensor & ~(N_APPROACH'(1) << green_idx);
   assign other_req = |others;

   // Flash request waives minimum green so the intersection can drop into night mode quickly
   assign green_exit = flash_en ||
                       ((timer >= MIN_LAST) && other_req &&
                        (!sensor[green_idx] || (timer == MAX_LAST)));

   rr_next_sel #(.N(N_APPROACH)) u_sel (
      .req   (sensor),
      .cur   (green_idx),
      .next  (rr_next),
      .valid (rr_valid)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         phase       <= GREEN;
         green_idx   <= '0;
         timer       <= '0;
         flash_phase <= 1'b0;
         from_flash  <= 1'b0;
      end else begin
         case (phase)
            GREEN: begin
               if (green_exit) begin
                  phase <= YELLOW;
                  timer <= '0;
               end else if (timer != MAX_LAST) begin
                  timer <= timer + 1'b1;
               end
            end
            YELLOW: begin
               if (timer == Y_LAST) begin
                  phase <= ALL_RED;
                  timer <= '0;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            ALL_RED: begin
               if (timer == AR_LAST) begin
                  timer      <= '0;
                  from_flash <= 1'b0;
                  if (flash_en) begin
                     phase       <= FLASH;
                     flash_phase <= 1'b1;
                  end else begin
                     phase <= GREEN;
                     if (from_flash)
                        green_idx <= '0;
                     else if (rr_valid)
                        green_idx <= rr_next;
                  end
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            FLASH: begin
               if (!flash_en) begin
                  phase      <= ALL_RED;
                  timer      <= '0;
                  from_flash <= 1'b1;
               end else if (timer == FH_LAST) begin
                  timer       <= '0;
                  flash_phase <= ~flash_phase;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            default: phase <= GREEN;
         endcase
      end
   end

   always_comb begin
      for (int i = 0; i < N_APPROACH; i++) lights[i] = LAMP_RED;
      case (phase)
         GREEN:   lights[green_idx] = LAMP_GRN;
         YELLOW:  lights[green_idx] = LAMP_YEL;
         FLASH: begin
            for (int i = 0; i < N_APPROACH; i++)
               lights[i] = flash_phase ? LAMP_YEL : LAMP_OFF;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_traffic_light_controller_n.sv
// tb/tb_traffic_light_controller_n.sv - scoreboard bench for traffic_light_controller_n at default parameters
module tb_traffic_light_controller_n;
   import tls_pkg::*;

   logic            clk;
   logic            reset;
   logic [3:0]      sensor;
   logic            flash_en;
   logic [3:0][2:0] lights;
   logic [1:0]      green_idx;
   phase_t          phase;

   int cmp_count = 0;
   int err_count = 0;

   typedef struct {
      phase_t ph;
      int     idx;
      logic   flon;
   } exp_t;

   exp_t exp_q[$];

   traffic_light_controller_n #(
      .N_APPROACH(4), .MIN_GREEN(4), .MAX_GREEN(8),
      .YELLOW_T(2), .ALLRED_T(1), .FLASH_HALF(2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .sensor    (sensor),
      .flash_en  (flash_en),
      .lights    (lights),
      .green_idx (green_idx),
      .phase     (phase)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [11:0] exp_lights(input phase_t ph, input int idx, input logic flon);
      logic [3:0][2:0] l;
      for (int i = 0; i < 4; i++) l[i] = 3'b100;
      if (ph == GREEN) l[idx] = 3'b001;
      else if (ph == YELLOW) l[idx] = 3'b010;
      else if (ph == FLASH) for (int i = 0; i < 4; i++) l[i] = flon ? 3'b010 : 3'b000;
      return l;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      cmp_count++;
      if (act !== req) begin
         err_count++;
         $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
      end
   endtask

   // Each step drives one cycle of inputs and records the state expected after the coming edge
   task automatic step(input logic [3:0] s, input logic f, input logic r,
                       input phase_t ph, input int idx, input logic flon, input int n);
      exp_t e;
      e.ph = ph; e.idx = idx; e.flon = flon;
      repeat (n) begin
         @(negedge clk);
         sensor = s; flash_en = f; reset = r;
         exp_q.push_back(e);
      end
   endtask

   always @(posedge clk) begin
      exp_t e;
      int   gy;
      logic ok;
      #1;
      gy = 0;
      ok = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (lights[i] == 3'b001 || lights[i] == 3'b010) gy++;
         if (lights[i] == 3'b001)
            for (int j = 0; j < 4; j++)
               if (j != i && lights[j] != 3'b100) ok = 1'b0;
      end
      if (phase != FLASH && gy > 1) ok = 1'b0;
      check("invariant", {31'd0, ok}, 32'd1);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("phase", 32'(phase), 32'(e.ph));
         if (e.idx >= 0) check("green_idx", 32'(green_idx), 32'(e.idx));
         check("lights", 32'(lights), 32'(exp_lights(e.ph, e.idx, e.flon)));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b0; sensor = 4'b0000; flash_en = 1'b0;

      // reset held, no traffic
      step(4'b0000, 0, 0, GREEN, 0, 0, 20);

      // single request on approach 2
      step(4'b0100, 0, 1, GREEN,   0, 0, 3);
      step(4'b0100, 0, 1, YELLOW,  0, 0, 2);
      step(4'b0100, 0, 1, ALL_RED, 0, 0, 1);
      step(4'b0100, 0, 1, GREEN,   2, 0, 4);

      // flashing mode from approach 2 green, exit returns to approach 0
      step(4'b0100, 1, 1, YELLOW,  2, 0, 2);
      step(4'b0100, 1, 1, ALL_RED, 2, 0, 1);
      for (int k = 0; k < 2; k++) begin
         step(4'b0100, 1, 1, FLASH, -1, 1, 2);
         step(4'b0100, 1, 1, FLASH, -1, 0, 2);
      end
      step(4'b0100, 0, 1, ALL_RED, -1, 0, 1);
      step(4'b0100, 0, 1, GREEN,    0, 0, 2);

      // two contending approaches, max green each
      step(4'b0101, 0, 0, GREEN,   0, 0, 2);
      step(4'b0101, 0, 1, GREEN,   0, 0, 7);
      step(4'b0101, 0, 1, YELLOW,  0, 0, 2);
      step(4'b0101, 0, 1, ALL_RED, 0, 0, 1);
      step(4'b0101, 0, 1, GREEN,   2, 0, 8);
      step(4'b0101, 0, 1, YELLOW,  2, 0, 2);
      step(4'b0101, 0, 1, ALL_RED, 2, 0, 1);
      step(4'b0101, 0, 1, GREEN,   0, 0, 1);

      // approaches 1 and 3 alternate, 0 and 2 never served
      step(4'b1010, 0, 0, GREEN,   0, 0, 2);
      step(4'b1010, 0, 1, GREEN,   0, 0, 3);
      step(4'b1010, 0, 1, YELLOW,  0, 0, 2);
      step(4'b1010, 0, 1, ALL_RED, 0, 0, 1);
      for (int k = 0; k < 2; k++) begin
         step(4'b1010, 0, 1, GREEN,   1, 0, 8);
         step(4'b1010, 0, 1, YELLOW,  1, 0, 2);
         step(4'b1010, 0, 1, ALL_RED, 1, 0, 1);
         step(4'b1010, 0, 1, GREEN,   3, 0, 8);
         step(4'b1010, 0, 1, YELLOW,  3, 0, 2);
         step(4'b1010, 0, 1, ALL_RED, 3, 0, 1);
      end
      step(4'b1010, 0, 1, GREEN, 1, 0, 1);

      // reset during yellow of approach 2
      step(4'b0100, 0, 0, GREEN,   0, 0, 2);
      step(4'b0100, 0, 1, GREEN,   0, 0, 3);
      step(4'b0100, 0, 1, YELLOW,  0, 0, 2);
      step(4'b0100, 0, 1, ALL_RED, 0, 0, 1);
      step(4'b0100, 0, 1, GREEN,   2, 0, 1);
      step(4'b0001, 0, 1, GREEN,   2, 0, 3);
      step(4'b0001, 0, 1, YELLOW,  2, 0, 1);
      step(4'b0001, 0, 0, GREEN,   0, 0, 1);
      step(4'b0001, 0, 1, GREEN,   0, 0, 2);

      begin
         int budget;
         budget = 10;
         while (exp_q.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
         end
         if (exp_q.size() > 0) begin
            cmp_count++;
            err_count++;
            $display("FAIL drain: actual=%0d pending required=0 pending", exp_q.size());
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
      $finish;
   end

endmodule
